// File: rtl/multiplier_control.sv
// Sequencer for an 8-bit add/shift multiplier: one ADD/SHIFT pair per multiplier bit, then holds the result.
// Define MULT_SKIP_ZERO_EN to fold the shift into ADD when the multiplier bit is zero (one cycle per zero bit).
module multiplier_control (
   input  logic Clk,
   input  logic Reset_n,
   input  logic Run,
   input  logic ClearA_LoadB,
   input  logic M,
   output logic Clr_Ld,
   output logic Ld_A,
   output logic Shift_En,
   output logic Fn,
   output logic Busy,
   output logic Done
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ADD   = 2'd1,
      SHIFT = 2'd2,
      HOLD  = 2'd3
   } state_t;

   state_t     r_state;
   state_t     w_state_nxt;
   logic [2:0] r_cnt;
   logic [2:0] w_cnt_nxt;
   logic       w_last_bit;

   assign w_last_bit = (r_cnt == 3'd7);

   always_ff @(posedge Clk) begin
      if (!Reset_n) begin
         r_state <= IDLE;
         r_cnt   <= 3'd0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      Clr_Ld      = 1'b0;
      Ld_A        = 1'b0;
      Shift_En    = 1'b0;
      Fn          = 1'b0;
      Busy        = 1'b0;
      Done        = 1'b0;
      case (r_state)
         IDLE: begin
            // Run wins over a simultaneous clear/load request.
            Clr_Ld = ClearA_LoadB & ~Run;
            if (Run) begin
               w_state_nxt = ADD;
               w_cnt_nxt   = 3'd0;
            end
         end
         ADD: begin
            Busy = 1'b1;
            Fn   = w_last_bit;
`ifdef MULT_SKIP_ZERO_EN
            if (M) begin
               Ld_A        = 1'b1;
               w_state_nxt = SHIFT;
            end else begin
               Shift_En = 1'b1;
               if (w_last_bit) begin
                  w_state_nxt = HOLD;
               end else begin
                  w_state_nxt = ADD;
                  w_cnt_nxt   = r_cnt + 3'd1;
               end
            end
`else
            Ld_A        = M;
            w_state_nxt = SHIFT;
`endif
         end
         SHIFT: begin
            Busy     = 1'b1;
            Shift_En = 1'b1;
            if (w_last_bit) begin
               w_state_nxt = HOLD;
            end else begin
               w_state_nxt = ADD;
               w_cnt_nxt   = r_cnt + 3'd1;
            end
         end
         HOLD: begin
            Done = 1'b1;
            // Wait for Run to drop so a held Run never retriggers.
            if (!Run) begin
               w_state_nxt = IDLE;
            end
         end
         default: begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = 3'd0;
         end
      endcase
   end

endmodule

// File: tb/tb_multiplier_control.sv
// Randomized bench for multiplier_control: a per-bit cycle list model gives the expected output trace.
module tb_multiplier_control;

   logic Clk;
   logic Reset_n;
   logic Run;
   logic ClearA_LoadB;
   logic M;
   logic Clr_Ld;
   logic Ld_A;
   logic Shift_En;
   logic Fn;
   logic Busy;
   logic Done;

   int n_checks = 0;
   int n_errors = 0;

   typedef struct {
      bit ld;
      bit sh;
      bit fn;
      int idx;
   } exp_t;

   multiplier_control dut (
      .Clk          (Clk),
      .Reset_n      (Reset_n),
      .Run          (Run),
      .ClearA_LoadB (ClearA_LoadB),
      .M            (M),
      .Clr_Ld       (Clr_Ld),
      .Ld_A         (Ld_A),
      .Shift_En     (Shift_En),
      .Fn           (Fn),
      .Busy         (Busy),
      .Done         (Done)
   );

   initial begin
      Clk = 1'b0;
      forever #5 Clk = ~Clk;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input int got, input int exp);
      n_checks++;
      if (got != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic chk_quiet(input string tag);
      chk({tag, "_ld_a"},     int'(Ld_A),     0);
      chk({tag, "_shift_en"}, int'(Shift_En), 0);
      chk({tag, "_fn"},       int'(Fn),       0);
      chk({tag, "_busy"},     int'(Busy),     0);
      chk({tag, "_done"},     int'(Done),     0);
   endtask

   // Expected per-cycle trace: each multiplier bit costs an ADD then a SHIFT;
   // with zero skipping a zero bit is a single shifting cycle.
   task automatic run_mult(input logic [7:0] b, input int hold_n, input int rst_at,
                           output int busy_out);
      exp_t q[$];
      exp_t e;
      int   busy_n = 0;
      int   sh_n   = 0;
      int   ld_n   = 0;
      int   ldfn_n = 0;
      int   both_n = 0;
      int   ones   = 0;
      busy_out = 0;
      for (int i = 0; i < 8; i++) begin
         ones += int'(b[i]);
`ifdef MULT_SKIP_ZERO_EN
         if (!b[i]) begin
            e = '{ld: 1'b0, sh: 1'b1, fn: (i == 7), idx: i};
            q.push_back(e);
            continue;
         end
`endif
         e = '{ld: b[i], sh: 1'b0, fn: (i == 7), idx: i};
         q.push_back(e);
         e = '{ld: 1'b0, sh: 1'b1, fn: 1'b0, idx: i};
         q.push_back(e);
      end

      Run          = 1'b1;
      ClearA_LoadB = 1'b1;
      M            = b[0];
      #1;
      chk("start_clr_ld", int'(Clr_Ld), 0);
      chk("start_busy",   int'(Busy),   0);

      for (int k = 0; k < q.size(); k++) begin
         @(posedge Clk);
         #1;
         Run          = 1'($urandom_range(0, 1));
         ClearA_LoadB = 1'($urandom_range(0, 1));
         M            = b[q[k].idx];
         #1;
         chk("busy_ld_a",     int'(Ld_A),     int'(q[k].ld));
         chk("busy_shift_en", int'(Shift_En), int'(q[k].sh));
         chk("busy_fn",       int'(Fn),       int'(q[k].fn));
         chk("busy_busy",     int'(Busy),     1);
         chk("busy_done",     int'(Done),     0);
         chk("busy_clr_ld",   int'(Clr_Ld),   0);
         busy_n += int'(Busy);
         sh_n   += int'(Shift_En);
         ld_n   += int'(Ld_A);
         ldfn_n += int'(Ld_A & Fn);
         both_n += int'(Ld_A & Shift_En);
         if (rst_at == q[k].idx && (k == 0 || q[k-1].idx != rst_at)) begin
            Reset_n      = 1'b0;
            Run          = 1'b1;
            ClearA_LoadB = 1'b1;
            for (int r = 0; r < 2; r++) begin
               @(posedge Clk);
               #1;
               chk_quiet("rst_mid");
               chk("rst_mid_clr_ld", int'(Clr_Ld), 0);
            end
            Reset_n      = 1'b1;
            Run          = 1'b0;
            ClearA_LoadB = 1'b0;
            @(posedge Clk);
            #1;
            chk_quiet("rst_after");
            return;
         end
      end
      busy_out = busy_n;
      chk("busy_cycles",   busy_n, q.size());
      chk("shift_pulses",  sh_n,   8);
      chk("ld_shift_both", both_n, 0);
      chk("ld_pulses",     ld_n,   ones);
      chk("ld_with_fn",    ldfn_n, int'(b[7]));

      for (int h = 0; h < hold_n; h++) begin
         @(posedge Clk);
         #1;
         Run          = (h < hold_n - 1);
         ClearA_LoadB = 1'($urandom_range(0, 1));
         #1;
         chk("hold_done",     int'(Done),     1);
         chk("hold_busy",     int'(Busy),     0);
         chk("hold_ld_a",     int'(Ld_A),     0);
         chk("hold_shift_en", int'(Shift_En), 0);
         chk("hold_fn",       int'(Fn),       0);
         chk("hold_clr_ld",   int'(Clr_Ld),   0);
      end
      @(posedge Clk);
      #1;
      Run          = 1'b0;
      ClearA_LoadB = 1'b0;
      #1;
      chk_quiet("end_idle");
      chk("end_idle_clr_ld", int'(Clr_Ld), 0);
   endtask

   initial begin
      int busy_cnt;
      int exp_07;
      Reset_n      = 1'b0;
      Run          = 1'b0;
      ClearA_LoadB = 1'b0;
      M            = 1'b0;
      repeat (2) @(posedge Clk);
      #1;
      chk_quiet("reset");
      Reset_n = 1'b1;
      @(posedge Clk);
      #1;
      chk_quiet("post_reset");

      ClearA_LoadB = 1'b1;
      #1;
      chk("idle_clr_ld_hi", int'(Clr_Ld), 1);
      ClearA_LoadB = 1'b0;
      #1;
      chk("idle_clr_ld_lo", int'(Clr_Ld), 0);

`ifdef MULT_SKIP_ZERO_EN
      exp_07 = 11;
`else
      exp_07 = 16;
`endif
      run_mult(8'h07, 1, -1, busy_cnt);
      chk("b07_busy_len", busy_cnt, exp_07);
      run_mult(8'h80, 1, -1, busy_cnt);
      run_mult(8'h5A, 10, -1, busy_cnt);
      run_mult(8'hC3, 1, -1, busy_cnt);
      run_mult(8'hFF, 1, 4, busy_cnt);
      run_mult(8'h00, 2, -1, busy_cnt);
      for (int n = 0; n < 8; n++) begin
         run_mult(8'($urandom), $urandom_range(1, 4), -1, busy_cnt);
      end
      run_mult(8'($urandom), 1, $urandom_range(0, 7), busy_cnt);
      run_mult(8'hA5, 3, -1, busy_cnt);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/multiplier_control.md
MULTIPLIER_CONTROL -- requirements
Module: multiplier_control

Interface
REQ-001 The block SHALL expose the following ports, one per line.
  Clk  input  1  system clock; all state changes on rising edge.
  Reset_n  input  1  synchronous, active-low reset.
  Run  input  1  start request, level, pre-synchronized.
  ClearA_LoadB  input  1  clear A/X and load B request, level, pre-synchronized.
  M  input  1  current multiplier LSB, B[0].
  Clr_Ld  output  1  datapath clears A and X and loads B this cycle.
  Ld_A  output  1  datapath loads the 9-bit add/sub result into X:A this cycle.
  Shift_En  output  1  datapath arithmetic-shifts X:A:B right by one this cycle.
  Fn  output  1  add/sub select to the 9-bit adder: 0 add, 1 subtract.
  Busy  output  1  high while a multiply is in progress.
  Done  output  1  high while holding a finished result.
REQ-002 The block SHALL be parameter-free.

Function
REQ-003 The FSM SHALL have states IDLE, ADD, SHIFT and HOLD, plus a 3-bit bit counter cnt.
REQ-004 In IDLE with Run=1, the block SHALL go to ADD with cnt=0 on the next edge and ignore ClearA_LoadB that cycle.
REQ-005 In IDLE with Run=0, Clr_Ld SHALL equal ClearA_LoadB, combinationally; it SHALL be 0 in every other state.
REQ-006 In ADD, Ld_A SHALL equal M, Fn SHALL be 1 when cnt=7 and 0 otherwise, and the next state SHALL be SHIFT.
REQ-007 In SHIFT, Shift_En SHALL be 1; if cnt=7 the next state SHALL be HOLD, else ADD with cnt incremented by one.
REQ-008 Ld_A and Shift_En SHALL never be asserted in the same cycle.
REQ-009 Fn SHALL be 0 in every state and cycle not covered by REQ-006.
REQ-010 Busy SHALL be 1 exactly in ADD and SHIFT; Done SHALL be 1 exactly in HOLD.
REQ-011 In HOLD the block SHALL stay until Run=0, then go to IDLE, so one Run assertion yields exactly one multiply.
REQ-012 Run and ClearA_LoadB changes while Busy=1 SHALL have no effect on sequencing.
REQ-013 A and X SHALL NOT be cleared at start, so consecutive multiplies accumulate in A:B as the datapath defines.
REQ-014 Without the REQ-019 macro, Run high in IDLE to HOLD SHALL take exactly 17 cycles: 16 Busy cycles, independent of M.

Reset
REQ-015 Reset_n=0 sampled on a rising edge SHALL force IDLE and cnt=0, including mid-multiply.
REQ-016 On the first cycle after reset, the outputs SHALL be Ld_A=0, Shift_En=0, Fn=0, Busy=0 and Done=0.
REQ-017 After reset, Clr_Ld SHALL follow REQ-005.
REQ-018 Reset SHALL take priority over Run and ClearA_LoadB.

Configuration
REQ-019 With macro MULT_SKIP_ZERO_EN defined, an ADD cycle with M=0 SHALL assert Shift_En instead of Ld_A.
REQ-020 With MULT_SKIP_ZERO_EN defined, that ADD cycle SHALL apply the REQ-007 counter and next-state rule, skipping SHIFT.
REQ-021 With MULT_SKIP_ZERO_EN defined, each zero bit SHALL cost 1 cycle and each one bit 2 cycles.
REQ-022 Without MULT_SKIP_ZERO_EN, behaviour SHALL be exactly as REQ-006 and REQ-007.

Verification
REQ-023 Reset_n=0 for 2 cycles mid-multiply at cnt=4, with Run=1 -> IDLE, Busy=0, Done=0, Ld_A=0, Shift_En=0, Fn=0.
REQ-024 B=0x07 (M sequence 1,1,1,0,0,0,0,0), Run pulse -> Ld_A high in ADD for cnt 0-2 with Fn=0; Busy 16 cycles; 11 cycles with MULT_SKIP_ZERO_EN.
REQ-025 B=0x80 (M=1 only at cnt=7) -> the single Ld_A pulse has Fn=1; Done rises after the 8th Shift_En.
REQ-026 Run held high through completion -> HOLD persists for 10 cycles with no restart; Run low then high -> second multiply starts; A not cleared.
REQ-027 ClearA_LoadB=1 in IDLE -> Clr_Ld=1 the same cycle; ClearA_LoadB=1 while Busy -> Clr_Ld=0; Run and ClearA_LoadB both 1 in IDLE -> ADD, Clr_Ld=0.
REQ-028 Every scenario -> Ld_A and Shift_En are never simultaneously 1, and exactly 8 Shift_En pulses occur per multiply.
